// File: rtl/bk_mem_pkg.sv
// Shared types for the BK SRAM arbiter: FSM encoding and byte-lane enables.
package bk_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VID_ACC,
    CPU_ACC,
    CPU_HOLD
  } state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  function automatic logic [1:0] cpu_be(
    input logic byte_op,
    input logic a0
  );
    if (!byte_op) return BE_WORD;
    return a0 ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/bk_mem_arbiter.sv
// SRAM word-port arbiter between the bkcore CPU bus and video scan-out.
// Define BK_MEMARB_FAIR_EN to cap consecutive video grants at MAX_VID_RUN.
module bk_mem_arbiter
  import bk_mem_pkg::*;
#(
  parameter int unsigned      AW          = 15,
  parameter int unsigned      WAIT_STATES = 1,
  parameter logic [AW-1:0]    SCREEN_BASE = 15'h2000,
  parameter int unsigned      MAX_VID_RUN = 4
) (
  input  logic          m_clock,
  input  logic          p_reset,
  input  logic          ce,
  input  logic          cpu_rd,
  input  logic          cpu_wt,
  input  logic          cpu_byte,
  input  logic [15:0]   cpu_adr,
  input  logic [15:0]   cpu_dout,
  output logic [15:0]   cpu_din,
  output logic          cpu_reply,
  input  logic          vid_req,
  input  logic [12:0]   vid_adr,
  output logic [15:0]   vid_data,
  output logic          vid_ack,
  output logic [AW-1:0] sram_adr,
  input  logic [15:0]   sram_dq_i,
  output logic [15:0]   sram_dq_o,
  output logic          sram_dq_oe,
  output logic          sram_we,
  output logic          sram_oe,
  output logic [1:0]    sram_be
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          last;
  logic          cpu_req, cpu_pend;
  logic          grant_vid, grant_cpu;
  logic          vid_cap;
  logic          wr_q, rom_q, keep_q;
  logic [1:0]    be_q;
  logic [15:0]   dq_q;

  assign last     = (cnt_q == CW'(WAIT_STATES));
  assign cpu_req  = cpu_rd | cpu_wt;
  assign cpu_pend = cpu_req & ~cpu_reply;

`ifdef BK_MEMARB_FAIR_EN
  localparam int RW = $clog2(MAX_VID_RUN + 1);
  logic [RW-1:0] vrun_q;

  assign vid_cap = (vrun_q == RW'(MAX_VID_RUN));

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      vrun_q <= '0;
    end else if (ce) begin
      if (grant_cpu)
        vrun_q <= '0;
      else if (grant_vid && !vid_cap)
        vrun_q <= vrun_q + 1'b1;
    end
  end
`else
  assign vid_cap = 1'b0;
`endif

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset)
      state_q <= IDLE;
    else if (ce)
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vid_req && !(vid_cap && cpu_pend)) begin
          grant_vid = 1'b1;
          state_d   = VID_ACC;
        end else if (cpu_pend) begin
          grant_cpu = 1'b1;
          state_d   = CPU_ACC;
        end
      end
      VID_ACC:
        if (last) state_d = IDLE;
      // a request dropped at any point of the access forfeits its reply
      CPU_ACC:
        if (last) state_d = (keep_q && cpu_req) ? CPU_HOLD : IDLE;
      CPU_HOLD:
        if (!cpu_req) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      cnt_q     <= '0;
      sram_adr  <= '0;
      be_q      <= 2'b00;
      wr_q      <= 1'b0;
      rom_q     <= 1'b0;
      keep_q    <= 1'b0;
      dq_q      <= '0;
      cpu_din   <= '0;
      cpu_reply <= 1'b0;
      vid_data  <= '0;
      vid_ack   <= 1'b0;
    end else if (ce) begin
      if ((state_q == VID_ACC || state_q == CPU_ACC) && !last)
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
      if (grant_vid) begin
        sram_adr <= SCREEN_BASE + AW'(vid_adr);
        be_q     <= BE_WORD;
        wr_q     <= 1'b0;
        rom_q    <= 1'b0;
      end
      if (grant_cpu) begin
        sram_adr <= cpu_adr[AW:1];
        be_q     <= cpu_be(cpu_byte, cpu_adr[0]);
        wr_q     <= cpu_wt;
        rom_q    <= cpu_adr[15];
        dq_q     <= cpu_dout;
        keep_q   <= 1'b1;
      end else if (state_q == CPU_ACC && !cpu_req) begin
        keep_q   <= 1'b0;
      end
      vid_ack <= (state_q == VID_ACC) && last;
      if (state_q == VID_ACC && last)
        vid_data <= sram_dq_i;
      if (state_q == CPU_ACC && last && !wr_q)
        cpu_din <= sram_dq_i;
      cpu_reply <= (state_d == CPU_HOLD);
    end
  end

  always_comb begin
    sram_oe    = 1'b0;
    sram_we    = 1'b0;
    sram_dq_oe = 1'b0;
    sram_be    = 2'b00;
    sram_dq_o  = dq_q;
    unique case (state_q)
      VID_ACC: begin
        sram_oe = 1'b1;
        sram_be = be_q;
      end
      // last write cycle drops we to hold address/data past the strobe
      CPU_ACC: begin
        sram_be = be_q;
        if (wr_q) begin
          sram_dq_oe = 1'b1;
          sram_we    = !rom_q && ((WAIT_STATES == 0) || !last);
        end else begin
          sram_oe    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bk_mem_arbiter.sv
// Directed bench for bk_mem_arbiter with a behavioural SRAM.
// Define BK_MEMARB_FAIR_EN for both DUT and bench to check the fair build.
module tb_bk_mem_arbiter;

  logic        m_clock = 1'b0;
  logic        p_reset;
  logic        ce;
  logic        cpu_rd, cpu_wt, cpu_byte;
  logic [15:0] cpu_adr, cpu_dout, cpu_din;
  logic        cpu_reply;
  logic        vid_req;
  logic [12:0] vid_adr;
  logic [15:0] vid_data;
  logic        vid_ack;
  logic [14:0] sram_adr;
  logic [15:0] sram_dq_i, sram_dq_o;
  logic        sram_dq_oe, sram_we, sram_oe;
  logic [1:0]  sram_be;

  logic [15:0] mem [0:32767];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  localparam logic [14:0] W0 = 15'h0100;

  always #5 m_clock = ~m_clock;

  bk_mem_arbiter dut (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .ce         (ce),
    .cpu_rd     (cpu_rd),
    .cpu_wt     (cpu_wt),
    .cpu_byte   (cpu_byte),
    .cpu_adr    (cpu_adr),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .cpu_reply  (cpu_reply),
    .vid_req    (vid_req),
    .vid_adr    (vid_adr),
    .vid_data   (vid_data),
    .vid_ack    (vid_ack),
    .sram_adr   (sram_adr),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_we    (sram_we),
    .sram_oe    (sram_oe),
    .sram_be    (sram_be)
  );

  assign sram_dq_i = mem[sram_adr];

  always @(posedge m_clock) begin
    if (ce && sram_we) begin
      if (sram_be[0]) mem[sram_adr][7:0]  <= sram_dq_o[7:0];
      if (sram_be[1]) mem[sram_adr][15:8] <= sram_dq_o[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge m_clock);
  endtask

  initial begin
    logic seen;
    int   acks;

    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[W0]       = 16'h1234;
    mem[15'h2005] = 16'hBEEF;

    p_reset = 1'b1; ce = 1'b1;
    cpu_rd = 1'b0; cpu_wt = 1'b0; cpu_byte = 1'b0;
    cpu_adr = '0; cpu_dout = '0;
    vid_req = 1'b0; vid_adr = '0;
    nclk(); nclk();
    chk("rst_reply", 32'(cpu_reply), 0);
    chk("rst_ack",   32'(vid_ack), 0);
    chk("rst_we",    32'(sram_we), 0);
    chk("rst_oe",    32'(sram_oe), 0);
    chk("rst_dqoe",  32'(sram_dq_oe), 0);
    chk("rst_be",    32'(sram_be), 0);
    chk("rst_adr",   32'(sram_adr), 0);
    chk("rst_din",   32'(cpu_din), 0);
    chk("rst_vdata", 32'(vid_data), 0);
    p_reset = 1'b0;
    nclk();

    // word read
    cpu_adr = 16'o001000; cpu_rd = 1'b1;
    nclk();
    chk("rd_oe",   32'(sram_oe), 1);
    chk("rd_adr",  32'(sram_adr), 32'(W0));
    chk("rd_be",   32'(sram_be), 32'h3);
    chk("rd_rep0", 32'(cpu_reply), 0);
    nclk();
    chk("rd_rep1", 32'(cpu_reply), 0);
    nclk();
    chk("rd_rep2", 32'(cpu_reply), 1);
    chk("rd_din",  32'(cpu_din), 32'h1234);
    cpu_rd = 1'b0;
    nclk();
    chk("rd_drop", 32'(cpu_reply), 0);
    chk("rd_hold", 32'(cpu_din), 32'h1234);

    // high byte write
    cpu_adr = 16'o001001; cpu_byte = 1'b1;
    cpu_dout = 16'hABAB; cpu_wt = 1'b1;
    nclk();
    chk("wb_we",   32'(sram_we), 1);
    chk("wb_be",   32'(sram_be), 32'h2);
    chk("wb_dqoe", 32'(sram_dq_oe), 1);
    chk("wb_dqo",  32'(sram_dq_o), 32'hABAB);
    chk("wb_adr",  32'(sram_adr), 32'(W0));
    chk("wb_oe",   32'(sram_oe), 0);
    nclk();
    chk("wb_we_last",   32'(sram_we), 0);
    chk("wb_dqoe_last", 32'(sram_dq_oe), 1);
    nclk();
    chk("wb_reply", 32'(cpu_reply), 1);
    chk("wb_mem",   32'(mem[W0]), 32'hAB34);
    cpu_wt = 1'b0; cpu_byte = 1'b0;
    nclk();

    // simultaneous video and CPU: video first
    vid_req = 1'b1; vid_adr = 13'h0005;
    cpu_adr = 16'o001000; cpu_rd = 1'b1;
    nclk();
    chk("vc_vadr", 32'(sram_adr), 32'h2005);
    chk("vc_voe",  32'(sram_oe), 1);
    chk("vc_vbe",  32'(sram_be), 32'h3);
    nclk();
    chk("vc_ack0", 32'(vid_ack), 0);
    nclk();
    chk("vc_ack",   32'(vid_ack), 1);
    chk("vc_vdata", 32'(vid_data), 32'hBEEF);
    chk("vc_norep", 32'(cpu_reply), 0);
    vid_req = 1'b0;
    nclk();
    chk("vc_ack_end", 32'(vid_ack), 0);
    chk("vc_cadr",    32'(sram_adr), 32'(W0));
    nclk(); nclk();
    chk("vc_reply", 32'(cpu_reply), 1);
    chk("vc_din",   32'(cpu_din), 32'hAB34);
    cpu_rd = 1'b0;
    nclk();

    // ROM write: no strobe, still replies
    cpu_adr = 16'o100000; cpu_dout = 16'h5555; cpu_wt = 1'b1;
    seen = 1'b0;
    nclk(); seen |= sram_we;
    nclk(); seen |= sram_we;
    nclk();
    chk("rom_reply", 32'(cpu_reply), 1);
    chk("rom_nowe",  32'(seen), 0);
    chk("rom_mem",   32'(mem[15'h4000]), 0);
    cpu_wt = 1'b0;
    nclk();

    // reset mid-access
    cpu_adr = 16'o001000; cpu_rd = 1'b1;
    nclk();
    chk("ar_inacc", 32'(sram_oe), 1);
    p_reset = 1'b1; cpu_rd = 1'b0;
    #1;
    chk("ar_oe",    32'(sram_oe), 0);
    chk("ar_adr",   32'(sram_adr), 0);
    chk("ar_din",   32'(cpu_din), 0);
    chk("ar_be",    32'(sram_be), 0);
    chk("ar_reply", 32'(cpu_reply), 0);
    nclk();
    p_reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nclk();
      seen |= cpu_reply | vid_ack;
    end
    chk("ar_quiet", 32'(seen), 0);

    // video streak against a waiting CPU read
    vid_req = 1'b1; vid_adr = 13'h0000;
    cpu_adr = 16'o001000; cpu_rd = 1'b1;
    acks = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      nclk();
      if (vid_ack) acks++;
      if (cpu_reply) seen = 1'b1;
    end
`ifdef BK_MEMARB_FAIR_EN
    chk("fair_cpu",  32'(seen), 1);
    chk("fair_acks", 32'(acks), 4);
`else
    chk("nofair_cpu",  32'(seen), 0);
    chk("nofair_acks", 32'(acks >= 15), 1);
`endif
    vid_req = 1'b0; cpu_rd = 1'b0;
    nclk(); nclk();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
